// File: rtl/uart_note_synth_pkg.sv
// Shared definitions for the UART-controlled note synthesizer.
// Holds the note-range constants, the rest code and the UART receiver state enum.
// Also holds the elaboration-time frequency and half-period functions used to build the note ROM.
package uart_note_synth_pkg;

  localparam int         NUM_NOTES = 88;
  // Any byte outside 1..NUM_NOTES plays silence; 0 is the canonical rest.
  localparam logic [7:0] REST_NOTE = 8'd0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic bit note_is_rest(input int n);
    return (n < 1) || (n > NUM_NOTES) || (n == int'(REST_NOTE));
  endfunction

  // Equal-tempered pitch with key 49 = A4 = 440 Hz.
  function automatic real note_hz_exact(input int n);
    return 440.0 * (2.0 ** ((real'(n) - 49.0) / 12.0));
  endfunction

  function automatic int note_hz(input int n);
    if (note_is_rest(n)) return 0;
    return $rtoi(note_hz_exact(n) + 0.5);
  endfunction

  // Rounded from the exact pitch, not from the rounded integer Hz.
  function automatic int note_half_period(input int n, input int clk_hz);
    if (note_is_rest(n)) return 0;
    return $rtoi(real'(clk_hz) / (2.0 * note_hz_exact(n)) + 0.5);
  endfunction

endpackage

// File: rtl/uart_note_synth_note_table.sv
// note_table: combinational ROM from note byte to (integer Hz, half period in clocks).
// Ports: note in; hz and half_period out. Rests (0, 89..255) give 0 for both.
// All entries are constants computed at elaboration; no runtime arithmetic.
module note_table
  import uart_note_synth_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic [7:0]  note,
  output logic [13:0] hz,
  output logic [23:0] half_period
);

  logic [13:0] hz_rom [256];
  logic [23:0] hp_rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam int HZ = note_hz(i);
    localparam int HP = note_half_period(i, CLK_HZ);
    assign hz_rom[i] = 14'(HZ);
    assign hp_rom[i] = 24'(HP);
  end

  assign hz          = hz_rom[note];
  assign half_period = hp_rom[note];

endmodule

// File: rtl/uart_note_synth.sv
// uart_note_synth: 8N1 UART note receiver driving a volume-gated PWM square wave.
// Ports: clk/rst_n, rx (idle high), volume (PWM duty); note, hz, ain, gain, shutdown_l out.
// Optional UART_FRAME_CHECK_EN: drop bytes whose stop bit samples low (default: accept them).
module uart_note_synth
  import uart_note_synth_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [7:0]  volume,
  output logic [7:0]  note,
  output logic [13:0] hz,
  output logic        ain,
  output logic        gain,
  output logic        shutdown_l
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BCW          = $clog2(CLKS_PER_BIT);

  // ---------------- UART receiver ----------------
  logic           rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_t    state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           byte_valid_q, byte_valid_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = START;
      end
      START: begin
        // Line must still be low half a bit in, otherwise it was a glitch.
        if (bit_cnt_q == BCW'(HALF_BIT - 1)) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt_q == BCW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt_q == BCW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
`ifdef UART_FRAME_CHECK_EN
          byte_valid_d = rx_sync_q;
`else
          byte_valid_d = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- note register and ROM ----------------
  logic [7:0]  note_q, note_d, note_prev_q;
  logic [23:0] half_period;

  always_comb begin
    note_d = byte_valid_q ? shift_q : note_q;
  end

  note_table #(.CLK_HZ(CLK_HZ)) u_note_table (
    .note        (note_q),
    .hz          (hz),
    .half_period (half_period)
  );

  // ---------------- tone generator ----------------
  logic [23:0] tone_cnt_q, tone_cnt_d;
  logic        phase_q, phase_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic        ain_q, ain_d;

  always_comb begin
    tone_cnt_d = tone_cnt_q + 1'b1;
    phase_d    = phase_q;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    // A note change restarts the tone so every note begins with a low half-period.
    if (half_period == '0 || note_q != note_prev_q) begin
      tone_cnt_d = '0;
      phase_d    = 1'b0;
    end else if (tone_cnt_q == half_period - 1'b1) begin
      tone_cnt_d = '0;
      phase_d    = !phase_q;
    end
    ain_d = phase_q && (pwm_cnt_q < volume);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronizer resets to idle-high so reset release never looks like a start edge.
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      note_q       <= REST_NOTE;
      note_prev_q  <= REST_NOTE;
      tone_cnt_q   <= '0;
      phase_q      <= 1'b0;
      pwm_cnt_q    <= '0;
      ain_q        <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      note_q       <= note_d;
      note_prev_q  <= note_q;
      tone_cnt_q   <= tone_cnt_d;
      phase_q      <= phase_d;
      pwm_cnt_q    <= pwm_cnt_d;
      ain_q        <= ain_d;
    end
  end

  assign note       = note_q;
  assign ain        = ain_q;
  assign gain       = 1'b1;
  assign shutdown_l = 1'b1;

endmodule

// File: tb/tb_uart_note_synth.sv
module tb_uart_note_synth;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  volume = 8'd0;
  logic [7:0]  note;
  logic [13:0] hz;
  logic        ain, gain, shutdown_l;

  uart_note_synth #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .volume     (volume),
    .note       (note),
    .hz         (hz),
    .ain        (ain),
    .gain       (gain),
    .shutdown_l (shutdown_l)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] note;
    int         hz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Scoreboard monitor: every observed note change pops one expected record.
  task automatic monitor();
    logic [7:0] last_note = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_note = 8'h00;
      end else if (note !== last_note) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_note_change", longint'(note), longint'(last_note));
        end else begin
          e = exp_q.pop_front();
          chk("sb_note", longint'(note), longint'(e.note));
          chk("sb_hz", longint'(hz), longint'(e.hz));
        end
        last_note = note;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop_bit;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] b, input int h);
    exp_t e;
    e.note = b;
    e.hz   = h;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clk);
    chk(name, longint'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  // Start of a high half-period: ain rises after at least 4 low cycles.
  task automatic find_rise(output bit ok, output int t);
    int lowrun = 0;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!ain) begin
        lowrun++;
      end else begin
        if (lowrun >= 4) begin
          ok = 1'b1;
          t  = cyc;
          return;
        end
        lowrun = 0;
      end
    end
  endtask

  task automatic check_period(input string name, input int expected);
    bit ok1, ok2;
    int t1, t2;
    find_rise(ok1, t1);
    find_rise(ok2, t2);
    chk({name, "_found"}, longint'(ok1 && ok2), 1);
    chk_rng(name, t2 - t1, expected - 1, expected + 1);
  endtask

  // Count ain over one full PWM frame well inside a high half-period.
  task automatic check_duty(input string name, input logic [7:0] vol);
    bit ok;
    int t, highs;
    volume = 8'd255;
    find_rise(ok, t);
    volume = vol;
    repeat (300) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (ain) highs++;
    end
    chk({name, "_found"}, longint'(ok), 1);
    chk(name, highs, longint'(vol));
  endtask

  task automatic check_silent(input string name, input int ncyc);
    int highs = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (ain) highs++;
    end
    chk(name, highs, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values; gain and shutdown_l must hold even while in reset.
    repeat (3) @(negedge clk);
    chk("rst_gain", longint'(gain), 1);
    chk("rst_shutdown_l", longint'(shutdown_l), 1);
    chk("rst_note", longint'(note), 0);
    chk("rst_hz", longint'(hz), 0);
    chk("rst_ain", longint'(ain), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // A4: 440 Hz, half period 1136 cycles.
    volume = 8'd255;
    expect_byte(8'h31, 440);
    send_byte(8'h31, 1'b1);
    wait_drain("drain_31");
    check_period("period_note49", 2272);
    check_duty("duty_vol255", 8'd255);
    check_duty("duty_vol64", 8'd64);
    volume = 8'd0;
    repeat (3) @(negedge clk);
    check_silent("silent_vol0", 2500);

    // Rest byte silences the output.
    volume = 8'd255;
    expect_byte(8'h00, 0);
    send_byte(8'h00, 1'b1);
    wait_drain("drain_00");
    check_silent("silent_rest0", 2500);

    // Note 89 is past the keyboard: a rest.
    expect_byte(8'h59, 0);
    send_byte(8'h59, 1'b1);
    wait_drain("drain_59");
    check_silent("silent_note89", 2500);

    // Note 88: top key, half period 119.
    expect_byte(8'h58, 4186);
    send_byte(8'h58, 1'b1);
    wait_drain("drain_58");
    check_period("period_note88", 238);

    // Note 1: bottom key.
    expect_byte(8'h01, 28);
    send_byte(8'h01, 1'b1);
    wait_drain("drain_01");

    // Reset during data bit 4 of 0xF5 (bits 4..7 and stop are high: no new start edge).
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("midrst_note", longint'(note), 0);
    chk("midrst_hz", longint'(hz), 0);
    chk("midrst_ain", longint'(ain), 0);

    // Clean byte after the aborted frame: note 40 = 262 Hz.
    expect_byte(8'h28, 262);
    send_byte(8'h28, 1'b1);
    wait_drain("drain_28");

    // Short low glitch must never start a frame.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (150) @(negedge clk);
    chk("glitch_note", longint'(note), 8'h28);

    // Stop bit forced low.
`ifdef UART_FRAME_CHECK_EN
    send_byte(8'h31, 1'b0);
    repeat (20) @(negedge clk);
    chk("badstop_note", longint'(note), 8'h28);
`else
    expect_byte(8'h31, 440);
    send_byte(8'h31, 1'b0);
    wait_drain("drain_badstop");
    chk("badstop_note", longint'(note), 8'h31);
`endif

    repeat (20) @(negedge clk);
    chk("final_queue_empty", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
